// File: rtl/floppy_fifo_drain_pkg.sv
// floppy_pkg: shared types and constants for the floppy FIFO read-side drain engine.
//   drain_state_t   : drain engine state encoding
//   DEFAULT_TIMEOUT : default number of consecutive empty-FIFO cycles tolerated in RUN
//   SECTOR_WORDS    : words in one floppy sector
package floppy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } drain_state_t;

  localparam int DEFAULT_TIMEOUT = 1024;
  localparam int SECTOR_WORDS    = 512;

endpackage

// File: rtl/floppy_fifo_drain_if.sv
// floppy_fifo_drain_if: FIFO read port plus the outgoing valid/ready word stream.
//   fifo_empty/fifo_q        : show-ahead FIFO status and head word (FIFO -> engine)
//   fifo_rdreq/fifo_sclr     : pop request and synchronous clear (engine -> FIFO)
//   out_valid/out_data/out_last : word stream (engine -> sink)
//   out_ready                : sink back-pressure (sink -> engine)
// master = drain engine side, slave = FIFO/sink environment side.
interface floppy_fifo_drain_if #(
  parameter int WIDTH = 8
) ();

  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_q;
  logic             fifo_rdreq;
  logic             fifo_sclr;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_ready;

  modport master (
    input  fifo_empty, fifo_q, out_ready,
    output fifo_rdreq, fifo_sclr, out_valid, out_data, out_last
  );

  modport slave (
    output fifo_empty, fifo_q, out_ready,
    input  fifo_rdreq, fifo_sclr, out_valid, out_data, out_last
  );

endinterface

// File: rtl/floppy_fifo_drain_out_reg.sv
// floppy_out_reg: single-entry valid/ready output register that holds its word on stall.
//   clk, rst_n        : clock, synchronous active-low reset
//   load, load_data, load_last : capture a new word (popped from the FIFO)
//   clear             : drop the held word (abort / underrun)
//   ready             : sink accepts when valid && ready
//   valid, data, last : registered stream outputs
module floppy_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             clear,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             last
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;

  // Next value of the holding register; data/last only change on load so they stay stable on stall.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Holding register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= {WIDTH{1'b0}};
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign last  = last_q;

endmodule

// File: rtl/floppy_fifo_drain.sv
// floppy_fifo_drain: pops a commanded number of words from the sector FIFO and streams them
// to the host/DMA sink with an end-of-transfer marker, underrun timeout and abort/flush.
//   clk, rst_n  : clock, synchronous active-low reset
//   start, len  : command strobe (honoured in IDLE) and word count
//   abort       : cancel transfer in any state; always flushes the FIFO
//   bus         : FIFO read port and output stream (master modport)
//   busy        : engine not in IDLE
//   done, err   : one-cycle completion pulse; err=1 for underrun or abort
module floppy_fifo_drain
  import floppy_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LEN_W   = 10,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  input  logic                abort,
  floppy_fifo_drain_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(TIMEOUT - 1);

  drain_state_t     state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             sclr_q, sclr_d;

  logic             pop;
  logic             accept;
  logic             clear_out;
  logic             ov;
  logic [WIDTH-1:0] od;
  logic             ol;

  assign accept = ov && bus.out_ready;
  // Pop only when the output slot is free or being emptied this cycle; abort blocks the pop.
  assign pop = (state_q == RUN) && !bus.fifo_empty && (remaining_q != {LEN_W{1'b0}})
               && (!ov || bus.out_ready) && !abort;

  // Next-state, counters and completion status; abort outranks start, timeout and pop.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    idle_cnt_d  = idle_cnt_q;
    err_d       = 1'b0;
    clear_out   = 1'b0;
    sclr_d      = abort;
    case (state_q)
      IDLE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (start && (len != {LEN_W{1'b0}})) begin
          state_d     = RUN;
          remaining_d = len;
          idle_cnt_d  = {CNT_W{1'b0}};
        end else if (start) begin
          state_d = DONE;
          err_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_d   = DONE;
          err_d     = 1'b1;
          clear_out = 1'b1;
        end else if (pop) begin
          remaining_d = remaining_q - LEN_W'(1);
          idle_cnt_d  = {CNT_W{1'b0}};
          if (remaining_q == LEN_W'(1)) begin
            state_d = DRAIN;
          end else begin
            state_d = RUN;
          end
        end else if (bus.fifo_empty && (remaining_q != {LEN_W{1'b0}})) begin
          // Underrun: the held word is discarded when the budget runs out.
          if (idle_cnt_q == IDLE_MAX) begin
            state_d   = DONE;
            err_d     = 1'b1;
            clear_out = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d   = DONE;
          err_d     = 1'b1;
          clear_out = 1'b1;
        end else if (accept) begin
          state_d = DONE;
          err_d   = 1'b0;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, counters and registered status outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= {LEN_W{1'b0}};
      idle_cnt_q  <= {CNT_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      sclr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      idle_cnt_q  <= idle_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      sclr_q      <= sclr_d;
    end
  end

  floppy_out_reg #(.WIDTH(WIDTH)) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (pop),
    .load_data (bus.fifo_q),
    .load_last (remaining_q == LEN_W'(1)),
    .clear     (clear_out),
    .ready     (bus.out_ready),
    .valid     (ov),
    .data      (od),
    .last      (ol)
  );

  assign bus.fifo_rdreq = pop;
  assign bus.fifo_sclr  = sclr_q;
  assign bus.out_valid  = ov;
  assign bus.out_data   = od;
  assign bus.out_last   = ol;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_floppy_fifo_drain.sv
// Testbench for floppy_fifo_drain: a queue models the show-ahead FIFO, a scoreboard holds
// the words the sink must receive (first len words of the FIFO, last flag on word len).
module tb_floppy_fifo_drain;
  localparam int WIDTH   = 8;
  localparam int LEN_W   = 10;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } word_t;

  logic             clk = 1'b0;
  logic             rst_n, start, abort, busy, done, err;
  logic [LEN_W-1:0] len;

  floppy_fifo_drain_if #(.WIDTH(WIDTH)) bus ();

  floppy_fifo_drain #(.WIDTH(WIDTH), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .bus(bus), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] fq[$];
  word_t      exp_q[$];
  int cycle_n = 0, done_cnt = 0, done_cycle = -1, last_acc_cycle = -1, last_pop_cycle = -1;
  int pops = 0, run = 0, max_run = 0;
  logic done_err = 1'b0;

  logic       rd_seen = 1'b0, sclr_seen = 1'b0, acc_seen = 1'b0, acc_last = 1'b0;
  logic [7:0] acc_data = 8'h00;

  // Capture edge events for the FIFO model and scoreboard.
  always @(posedge clk) begin
    rd_seen   <= bus.fifo_rdreq;
    sclr_seen <= bus.fifo_sclr;
    acc_seen  <= bus.out_valid && bus.out_ready;
    acc_data  <= bus.out_data;
    acc_last  <= bus.out_last;
  end

  task automatic refresh_fifo();
    bus.fifo_empty = (fq.size() == 0);
    bus.fifo_q     = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic build_exp(input int n);
    word_t w;
    exp_q.delete();
    for (int i = 0; i < n && i < fq.size(); i++) begin
      w.d = fq[i];
      w.l = (i == n - 1);
      exp_q.push_back(w);
    end
  endtask

  // One clock: check stall rule, advance, update FIFO model and scoreboard at negedge.
  task automatic cycle();
    word_t w;
    #1;
    vectors++;
    if (bus.fifo_rdreq === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b0) begin
      miscompares++;
      $display("FAIL rdreq_while_stalled: rdreq=1 with out_valid=1 out_ready=0 at cycle %0d", cycle_n);
    end
    @(posedge clk);
    @(negedge clk);
    cycle_n++;
    if (sclr_seen) begin
      fq.delete();
    end else if (rd_seen) begin
      void'(fq.pop_front());
      pops++;
      last_pop_cycle = cycle_n;
    end
    if (rd_seen) run++; else run = 0;
    if (run > max_run) max_run = run;
    refresh_fifo();
    if (acc_seen) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_word: got %02h last=%b, want none", acc_data, acc_last);
      end else begin
        w = exp_q.pop_front();
        if (acc_data !== w.d || acc_last !== w.l) begin
          miscompares++;
          $display("FAIL word_order: got %02h last=%b, want %02h last=%b", acc_data, acc_last, w.d, w.l);
        end
      end
      if (acc_last) last_acc_cycle = cycle_n;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_err   = err;
      done_cycle = cycle_n;
    end
    vectors++;
    if (done !== 1'b1 && err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_without_done: got err=%b done=%b, want err=0", err, done);
    end
  endtask

  task automatic wait_done(input int budget, input string name, input bit rand_ready);
    int d0 = done_cnt;
    for (int k = 0; k < budget && done_cnt == d0; k++) begin
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    vectors++;
    if (done_cnt == d0) begin
      miscompares++;
      $display("FAIL %s_timeout: got no done within %0d cycles, want done", name, budget);
    end
  endtask

  task automatic start_cmd(input int n);
    start = 1'b1;
    len   = LEN_W'(n);
    cycle();
    start = 1'b0;
  endtask

  // Go idle, flush leftovers with an abort in IDLE: sclr only, no done.
  task automatic flush_idle(input string name);
    int d0;
    for (int k = 0; k < 4 && busy !== 1'b0; k++) cycle();
    d0 = done_cnt;
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    vectors++;
    if ({bus.fifo_sclr, done, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL %s_idle_abort: got sclr/done/busy=%b, want 100", name, {bus.fifo_sclr, done, busy});
    end
    cycle();
    vectors++;
    if (fq.size() != 0 || bus.fifo_sclr !== 1'b0 || done_cnt != d0) begin
      miscompares++;
      $display("FAIL %s_flush: got fifo=%0d sclr=%b dones=%0d, want 0 0 %0d", name, fq.size(), bus.fifo_sclr, done_cnt, d0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; len = '0; bus.out_ready = 1'b0;
    refresh_fifo();
    cycle();
    cycle();
    vectors++;
    if ({busy, done, err, bus.out_valid, bus.out_last, bus.fifo_sclr, bus.fifo_rdreq} !== 7'b0 || bus.out_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state: got %b data=%02h, want 0000000 data=00",
               {busy, done, err, bus.out_valid, bus.out_last, bus.fifo_sclr, bus.fifo_rdreq}, bus.out_data);
    end
    rst_n = 1'b1;
    cycle();
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_idle: got busy/done=%b, want 00", {busy, done});
    end
  endtask

  task automatic test_sector();
    int d0 = done_cnt;
    fq.delete();
    for (int i = 0; i < 512; i++) fq.push_back(8'(i));
    refresh_fifo();
    bus.out_ready = 1'b1;
    build_exp(512);
    pops = 0; run = 0; max_run = 0;
    start_cmd(512);
    wait_done(600, "sector", 1'b0);
    vectors++;
    if (pops != 512 || max_run != 512 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sector_pops: got pops=%0d run=%0d left=%0d, want 512 512 0", pops, max_run, exp_q.size());
    end
    vectors++;
    if (done_err !== 1'b0 || done_cycle != last_acc_cycle || done_cnt != d0 + 1) begin
      miscompares++;
      $display("FAIL sector_done: got err=%b done@%0d last@%0d, want err=0 same cycle", done_err, done_cycle, last_acc_cycle);
    end
    cycle();
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL sector_idle: got busy/done=%b, want 00", {busy, done});
    end
  endtask

  task automatic test_stall();
    logic       pv, pr, pl;
    logic [7:0] pd;
    int d0 = done_cnt;
    fq.delete();
    for (int i = 0; i < 6; i++) fq.push_back(8'($urandom));
    refresh_fifo();
    build_exp(4);
    bus.out_ready = 1'b1;
    start_cmd(4);
    for (int k = 0; k < 60 && done_cnt == d0; k++) begin
      bus.out_ready = (k % 3 == 0);
      pv = bus.out_valid; pr = bus.out_ready; pd = bus.out_data; pl = bus.out_last;
      cycle();
      if (pv && !pr) begin
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== pd || bus.out_last !== pl) begin
          miscompares++;
          $display("FAIL stall_hold: got v=%b %02h l=%b, want v=1 %02h l=%b", bus.out_valid, bus.out_data, bus.out_last, pd, pl);
        end
      end
    end
    vectors++;
    if (done_cnt != d0 + 1 || done_err !== 1'b0 || exp_q.size() != 0 || fq.size() != 2) begin
      miscompares++;
      $display("FAIL stall_result: got dones=%0d err=%b left=%0d fifo=%0d, want %0d 0 0 2", done_cnt - d0, done_err, exp_q.size(), fq.size(), 1);
    end
    flush_idle("stall");
  endtask

  task automatic test_len_zero();
    int p0 = pops;
    int d0 = done_cnt;
    fq.push_back(8'($urandom));
    fq.push_back(8'($urandom));
    refresh_fifo();
    exp_q.delete();
    start_cmd(0);
    vectors++;
    if ({done, err, busy} !== 3'b101) begin
      miscompares++;
      $display("FAIL len0_done: got done/err/busy=%b, want 101", {done, err, busy});
    end
    cycle();
    vectors++;
    if ({done, busy} !== 2'b00 || pops != p0 || done_cnt != d0 + 1) begin
      miscompares++;
      $display("FAIL len0_after: got done/busy=%b pops=%0d, want 00 0", {done, busy}, pops - p0);
    end
    flush_idle("len0");
  endtask

  task automatic test_timeout();
    int p0 = pops;
    for (int i = 0; i < 3; i++) fq.push_back(8'($urandom));
    refresh_fifo();
    build_exp(8);
    bus.out_ready = 1'b1;
    start_cmd(8);
    wait_done(80, "underrun", 1'b0);
    vectors++;
    if (done_err !== 1'b1 || exp_q.size() != 0 || pops != p0 + 3) begin
      miscompares++;
      $display("FAIL underrun_result: got err=%b left=%0d pops=%0d, want 1 0 3", done_err, exp_q.size(), pops - p0);
    end
    vectors++;
    if (done_cycle != last_pop_cycle + TIMEOUT || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL underrun_timing: got %0d empty cycles valid=%b, want %0d valid=0", done_cycle - last_pop_cycle, bus.out_valid, TIMEOUT);
    end
    cycle();
    vectors++;
    if ({busy, bus.out_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL underrun_idle: got busy/valid=%b, want 00", {busy, bus.out_valid});
    end
  endtask

  task automatic test_abort();
    int p0 = pops;
    int d0 = done_cnt;
    for (int i = 0; i < 10; i++) fq.push_back(8'($urandom));
    refresh_fifo();
    build_exp(8);
    bus.out_ready = 1'b1;
    start_cmd(8);
    for (int k = 0; k < 20 && pops < p0 + 3; k++) cycle();
    abort = 1'b1;
    #1;
    vectors++;
    if (bus.fifo_rdreq !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_nopop: got rdreq=%b, want 0", bus.fifo_rdreq);
    end
    cycle();
    abort = 1'b0;
    vectors++;
    if ({bus.fifo_sclr, done, err, bus.out_valid, busy} !== 5'b11101) begin
      miscompares++;
      $display("FAIL abort_done: got sclr/done/err/valid/busy=%b, want 11101", {bus.fifo_sclr, done, err, bus.out_valid, busy});
    end
    vectors++;
    if (pops != p0 + 3 || exp_q.size() != 5) begin
      miscompares++;
      $display("FAIL abort_words: got pops=%0d left=%0d, want 3 5", pops - p0, exp_q.size());
    end
    exp_q.delete();
    start_cmd(2);
    vectors++;
    if ({busy, done, bus.fifo_sclr} !== 3'b000 || fq.size() != 0 || done_cnt != d0 + 1) begin
      miscompares++;
      $display("FAIL abort_start_ignored: got busy/done/sclr=%b fifo=%0d, want 000 0", {busy, done, bus.fifo_sclr}, fq.size());
    end
    for (int i = 0; i < 4; i++) fq.push_back(8'($urandom));
    refresh_fifo();
    build_exp(4);
    start_cmd(4);
    wait_done(40, "abort_restart", 1'b0);
    vectors++;
    if (done_err !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL abort_restart: got err=%b left=%0d, want 0 0", done_err, exp_q.size());
    end
    cycle();
  endtask

  task automatic test_reset_mid();
    int p0 = pops;
    int d0;
    for (int i = 0; i < 10; i++) fq.push_back(8'($urandom));
    refresh_fifo();
    build_exp(8);
    bus.out_ready = 1'b1;
    start_cmd(8);
    for (int k = 0; k < 20 && pops < p0 + 3; k++) cycle();
    d0 = done_cnt;
    rst_n = 1'b0;
    cycle();
    vectors++;
    if ({busy, done, err, bus.out_valid, bus.out_last, bus.fifo_sclr, bus.fifo_rdreq} !== 7'b0 || bus.out_data !== 8'h00 || done_cnt != d0) begin
      miscompares++;
      $display("FAIL midreset_state: got %b data=%02h, want 0000000 data=00",
               {busy, done, err, bus.out_valid, bus.out_last, bus.fifo_sclr, bus.fifo_rdreq}, bus.out_data);
    end
    rst_n = 1'b1;
    exp_q.delete();
    fq.delete();
    for (int i = 0; i < 5; i++) fq.push_back(8'($urandom));
    refresh_fifo();
    build_exp(5);
    start_cmd(5);
    wait_done(200, "midreset_restart", 1'b1);
    vectors++;
    if (done_err !== 1'b0 || exp_q.size() != 0 || fq.size() != 0 || done_cnt != d0 + 1) begin
      miscompares++;
      $display("FAIL midreset_restart: got err=%b left=%0d fifo=%0d, want 0 0 0", done_err, exp_q.size(), fq.size());
    end
    bus.out_ready = 1'b1;
    cycle();
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int n = $urandom_range(1, 24);
      int extra = $urandom_range(0, 3);
      for (int i = 0; i < n + extra; i++) fq.push_back(8'($urandom));
      refresh_fifo();
      build_exp(n);
      bus.out_ready = 1'($urandom_range(0, 1));
      start_cmd(n);
      wait_done(400, "random", 1'b1);
      vectors++;
      if (done_err !== 1'b0 || exp_q.size() != 0 || fq.size() != extra) begin
        miscompares++;
        $display("FAIL random_len%0d: got err=%b left=%0d fifo=%0d, want 0 0 %0d", n, done_err, exp_q.size(), fq.size(), extra);
      end
      bus.out_ready = 1'b1;
      flush_idle("random");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, want finish");
    $fatal(1);
  end

  initial begin
    bus.out_ready = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_q = 8'h00;
    test_reset();
    test_sector();
    test_stall();
    test_len_zero();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
